// File: rtl/register_file_multi_pkg.sv
// Shared widths and the {valid, tag, data} operand record for the renaming register file.
package register_file_multi_pkg;

    localparam int REG_WIDTH  = 6;
    localparam int ROB_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_REGS   = 1 << REG_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [ROB_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } cdb_t;

    function automatic cdb_t cdb_reset_value();
        cdb_t r;
        r.valid = 1'b1;
        r.tag   = '0;
        r.data  = '0;
        return r;
    endfunction

endpackage

// File: rtl/register_file_entry.sv
// One architectural register: valid/tag/data state plus its own issue and commit match logic.
// Highest matching lane wins for both the tag (issue) and the data (commit) writes.
module register_file_entry
    import register_file_multi_pkg::*;
#(
    parameter int          ISSUE_WIDTH  = 2,
    parameter int          COMMIT_WIDTH = 2,
    parameter int unsigned IDX          = 0
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     flush_i,
    input  logic [ISSUE_WIDTH-1:0]                   issue_valid_i,
    input  logic [ISSUE_WIDTH-1:0][REG_WIDTH-1:0]    issue_dst_i,
    input  logic [ISSUE_WIDTH-1:0][ROB_WIDTH-1:0]    issue_tag_i,
    input  logic [COMMIT_WIDTH-1:0]                  commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0][REG_WIDTH-1:0]   commit_arch_num_i,
    input  logic [COMMIT_WIDTH-1:0][ROB_WIDTH-1:0]   commit_tag_i,
    input  logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]  commit_data_i,
    output cdb_t                                     entry_o
);

    localparam logic [REG_WIDTH-1:0] MY_IDX = IDX[REG_WIDTH-1:0];

    logic                  valid_q, valid_d;
    logic [ROB_WIDTH-1:0]  tag_q, tag_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  issue_hit;
    logic                  commit_tag_hit;

    always_comb begin
        issue_hit      = 1'b0;
        tag_d          = tag_q;
        commit_tag_hit = 1'b0;
        data_d         = data_q;
        for (int m = 0; m < ISSUE_WIDTH; m++) begin
            if (issue_valid_i[m] && !flush_i && issue_dst_i[m] == MY_IDX) begin
                issue_hit = 1'b1;
                tag_d     = issue_tag_i[m];
            end
        end
        // Data is architectural: any commit to this index writes it, whatever the tag or flush.
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (commit_valid_i[c] && commit_tag_i[c] == tag_q)
                commit_tag_hit = 1'b1;
            if (commit_valid_i[c] && commit_arch_num_i[c] == MY_IDX)
                data_d = commit_data_i[c];
        end
        if (flush_i)
            valid_d = 1'b1;
        else if (issue_hit)
            valid_d = 1'b0;
        else if (!valid_q && commit_tag_hit)
            valid_d = 1'b1;
        else
            valid_d = valid_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b1;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign entry_o = '{valid: valid_q, tag: tag_q, data: data_q};

endmodule

// File: rtl/register_file_multi.sv
// Multi-issue renaming register file; source reads are combinational with intra-group
// rename forwarding and same-cycle commit bypass.
module register_file_multi
    import register_file_multi_pkg::*;
#(
    parameter int ISSUE_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int SRC_PER_INST = 2
) (
    input  logic                                                  clk,
    input  logic                                                  reset_n,
    input  logic                                                  flush,
    input  logic [ISSUE_WIDTH-1:0]                                issue_valid,
    input  logic [ISSUE_WIDTH-1:0][REG_WIDTH-1:0]                 issue_dst,
    input  logic [ISSUE_WIDTH-1:0][ROB_WIDTH-1:0]                 issue_tag,
    input  logic [ISSUE_WIDTH-1:0][SRC_PER_INST-1:0][REG_WIDTH-1:0] src_num,
    output cdb_t [ISSUE_WIDTH-1:0][SRC_PER_INST-1:0]              src_read,
    input  logic [COMMIT_WIDTH-1:0]                               commit_valid,
    input  logic [COMMIT_WIDTH-1:0][REG_WIDTH-1:0]                commit_arch_num,
    input  logic [COMMIT_WIDTH-1:0][ROB_WIDTH-1:0]                commit_tag,
    input  logic [COMMIT_WIDTH-1:0][DATA_WIDTH-1:0]               commit_data
);

    cdb_t entry_q [NUM_REGS];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        register_file_entry #(
            .ISSUE_WIDTH (ISSUE_WIDTH),
            .COMMIT_WIDTH(COMMIT_WIDTH),
            .IDX         (g)
        ) u_entry (
            .clk              (clk),
            .reset_n          (reset_n),
            .flush_i          (flush),
            .issue_valid_i    (issue_valid),
            .issue_dst_i      (issue_dst),
            .issue_tag_i      (issue_tag),
            .commit_valid_i   (commit_valid),
            .commit_arch_num_i(commit_arch_num),
            .commit_tag_i     (commit_tag),
            .commit_data_i    (commit_data),
            .entry_o          (entry_q[g])
        );
    end

    always_comb begin
        cdb_t stored;
        cdb_t rd;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            for (int k = 0; k < SRC_PER_INST; k++) begin
                stored = entry_q[src_num[j][k]];
                rd     = stored;
                if (!stored.valid) begin
                    for (int c = 0; c < COMMIT_WIDTH; c++) begin
                        if (commit_valid[c] && commit_tag[c] == stored.tag) begin
                            rd.valid = 1'b1;
                            rd.data  = commit_data[c];
                        end
                    end
                end
                // Ascending scan so the nearest older lane overrides farther ones.
                for (int m = 0; m < ISSUE_WIDTH; m++) begin
                    if (m < j && issue_valid[m] && !flush && issue_dst[m] == src_num[j][k]) begin
                        rd.valid = 1'b0;
                        rd.tag   = issue_tag[m];
                        rd.data  = '0;
                    end
                end
                src_read[j][k] = rd;
            end
        end
    end

endmodule

// File: tb/tb_register_file_multi.sv
// Directed vector table for the documented scenarios, then randomized traffic checked
// against an array-based model of the register file.
module tb_register_file_multi;
    import register_file_multi_pkg::*;

    localparam int IW = 2;
    localparam int CW = 2;
    localparam int SP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                   reset_n;
    logic                                   flush;
    logic [IW-1:0]                          issue_valid;
    logic [IW-1:0][REG_WIDTH-1:0]           issue_dst;
    logic [IW-1:0][ROB_WIDTH-1:0]           issue_tag;
    logic [IW-1:0][SP-1:0][REG_WIDTH-1:0]   src_num;
    cdb_t [IW-1:0][SP-1:0]                  src_read;
    logic [CW-1:0]                          commit_valid;
    logic [CW-1:0][REG_WIDTH-1:0]           commit_arch_num;
    logic [CW-1:0][ROB_WIDTH-1:0]           commit_tag;
    logic [CW-1:0][DATA_WIDTH-1:0]          commit_data;

    register_file_multi #(.ISSUE_WIDTH(IW), .COMMIT_WIDTH(CW), .SRC_PER_INST(SP)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_dst      (issue_dst),
        .issue_tag      (issue_tag),
        .src_num        (src_num),
        .src_read       (src_read),
        .commit_valid   (commit_valid),
        .commit_arch_num(commit_arch_num),
        .commit_tag     (commit_tag),
        .commit_data    (commit_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        fl;
        logic [10:0] i0, i1;       // {valid, dst, tag}
        logic [42:0] c0, c1;       // {valid, arch, tag, data}
        int          lane;
        logic [5:0]  rd;
        logic        chk;
        logic        ev;
        logic [3:0]  et;
        logic        chkd;
        logic [31:0] ed;
    } vec_t;

    function automatic vec_t mk(logic rst_n, logic fl, logic [10:0] i0, logic [10:0] i1,
                                logic [42:0] c0, logic [42:0] c1, int lane, logic [5:0] rd,
                                logic chk, logic ev, logic [3:0] et, logic chkd, logic [31:0] ed);
        vec_t v;
        v.rst_n = rst_n; v.fl = fl; v.i0 = i0; v.i1 = i1; v.c0 = c0; v.c1 = c1;
        v.lane = lane; v.rd = rd; v.chk = chk; v.ev = ev; v.et = et; v.chkd = chkd; v.ed = ed;
        return v;
    endfunction

    // Reference model state
    logic        m_v [NUM_REGS];
    logic [3:0]  m_t [NUM_REGS];
    logic [31:0] m_d [NUM_REGS];

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_v[i] = 1'b1; m_t[i] = '0; m_d[i] = '0;
        end
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                logic       iss, cm;
                logic [3:0] it;
                iss = 1'b0; cm = 1'b0; it = m_t[i];
                if (!flush)
                    for (int m = 0; m < IW; m++)
                        if (issue_valid[m] && issue_dst[m] == i[5:0]) begin iss = 1'b1; it = issue_tag[m]; end
                for (int c = 0; c < CW; c++) begin
                    if (commit_valid[c] && commit_tag[c] == m_t[i]) cm = 1'b1;
                    if (commit_valid[c] && commit_arch_num[c] == i[5:0]) m_d[i] = commit_data[c];
                end
                if (flush)              m_v[i] = 1'b1;
                else if (iss)           m_v[i] = 1'b0;
                else if (!m_v[i] && cm) m_v[i] = 1'b1;
                m_t[i] = it;
            end
        end
    endtask

    task automatic model_read(input int j, input logic [5:0] s, output logic ev,
                              output logic [3:0] et, output logic [31:0] ed, output logic fwd);
        ev = m_v[s]; et = m_t[s]; ed = m_d[s]; fwd = 1'b0;
        if (!m_v[s])
            for (int c = 0; c < CW; c++)
                if (commit_valid[c] && commit_tag[c] == m_t[s]) begin ev = 1'b1; ed = commit_data[c]; end
        if (!flush)
            for (int m = j - 1; m >= 0; m--)
                if (!fwd && issue_valid[m] && issue_dst[m] == s) begin
                    ev = 1'b0; et = issue_tag[m]; fwd = 1'b1;
                end
    endtask

    task automatic drive_vec(input vec_t v);
        reset_n = v.rst_n;
        flush   = v.fl;
        {issue_valid[0], issue_dst[0], issue_tag[0]} = v.i0;
        {issue_valid[1], issue_dst[1], issue_tag[1]} = v.i1;
        {commit_valid[0], commit_arch_num[0], commit_tag[0], commit_data[0]} = v.c0;
        {commit_valid[1], commit_arch_num[1], commit_tag[1], commit_data[1]} = v.c1;
        for (int j = 0; j < IW; j++)
            for (int k = 0; k < SP; k++)
                src_num[j][k] = v.rd;
    endtask

    localparam logic [10:0] NI = '0;
    localparam logic [42:0] NC = '0;

    vec_t vecs [27];

    initial begin
        vecs[0]  = mk(0, 0, NI, NI, NC, NC, 0, 6'd5, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, NI, NI, NC, NC, 0, 6'd5, 1, 1, 0, 1, 0);
        vecs[2]  = mk(1, 0, {1'b1, 6'd3, 4'd7}, NI, NC, NC, 0, 6'd3, 1, 1, 0, 1, 0);
        vecs[3]  = mk(1, 0, NI, NI, {1'b1, 6'd3, 4'd7, 32'hDEADBEEF}, NC, 0, 6'd3, 1, 1, 7, 1, 32'hDEADBEEF);
        vecs[4]  = mk(1, 0, NI, NI, NC, NC, 0, 6'd3, 1, 1, 7, 1, 32'hDEADBEEF);
        vecs[5]  = mk(1, 0, {1'b1, 6'd4, 4'd2}, {1'b1, 6'd4, 4'd3}, NC, NC, 1, 6'd4, 1, 0, 2, 0, 0);
        vecs[6]  = mk(1, 0, NI, NI, NC, NC, 0, 6'd4, 1, 0, 3, 1, 0);
        vecs[7]  = mk(1, 0, {1'b1, 6'd6, 4'd1}, NI, NC, NC, 0, 6'd6, 1, 1, 0, 1, 0);
        vecs[8]  = mk(1, 0, {1'b1, 6'd6, 4'd5}, NI, NC, NC, 0, 6'd6, 1, 0, 1, 1, 0);
        vecs[9]  = mk(1, 0, NI, NI, {1'b1, 6'd6, 4'd1, 32'h11}, NC, 0, 6'd6, 1, 0, 5, 1, 0);
        vecs[10] = mk(1, 0, NI, NI, NC, NC, 0, 6'd6, 1, 0, 5, 1, 32'h11);
        vecs[11] = mk(1, 0, NI, NI, {1'b1, 6'd6, 4'd5, 32'h66}, NC, 0, 6'd6, 1, 1, 5, 1, 32'h66);
        vecs[12] = mk(1, 0, NI, NI, NC, NC, 0, 6'd6, 1, 1, 5, 1, 32'h66);
        vecs[13] = mk(1, 0, {1'b1, 6'd10, 4'd8}, {1'b1, 6'd11, 4'd9}, NC, NC, 0, 6'd10, 1, 1, 0, 1, 0);
        vecs[14] = mk(1, 1, {1'b1, 6'd2, 4'd4}, NI, {1'b1, 6'd9, 4'd12, 32'h55}, NC, 1, 6'd2, 1, 1, 0, 1, 0);
        vecs[15] = mk(1, 0, NI, NI, NC, NC, 0, 6'd10, 1, 1, 8, 1, 0);
        vecs[16] = mk(1, 0, NI, NI, NC, NC, 0, 6'd4, 1, 1, 3, 1, 0);
        vecs[17] = mk(1, 0, NI, NI, NC, NC, 0, 6'd2, 1, 1, 0, 1, 0);
        vecs[18] = mk(1, 0, NI, NI, NC, NC, 0, 6'd9, 1, 1, 0, 1, 32'h55);
        vecs[19] = mk(1, 0, {1'b1, 6'd8, 4'd6}, NI, NC, NC, 0, 6'd8, 1, 1, 0, 1, 0);
        vecs[20] = mk(1, 0, NI, NI, {1'b1, 6'd8, 4'd6, 32'hA}, {1'b1, 6'd8, 4'd6, 32'hB}, 0, 6'd8, 1, 1, 6, 0, 0);
        vecs[21] = mk(1, 0, NI, NI, NC, NC, 0, 6'd8, 1, 1, 6, 1, 32'hB);
        vecs[22] = mk(1, 0, {1'b1, 6'd8, 4'd7}, NI, NC, NC, 0, 6'd8, 1, 1, 6, 1, 32'hB);
        vecs[23] = mk(0, 0, {1'b1, 6'd12, 4'd3}, NI, {1'b1, 6'd3, 4'd9, 32'h77}, NC, 0, 6'd8, 1, 0, 7, 1, 32'hB);
        vecs[24] = mk(1, 0, NI, NI, NC, NC, 0, 6'd8, 1, 1, 0, 1, 0);
        vecs[25] = mk(1, 0, NI, NI, NC, NC, 0, 6'd3, 1, 1, 0, 1, 0);
        vecs[26] = mk(1, 0, NI, NI, NC, NC, 0, 6'd12, 1, 1, 0, 1, 0);

        for (int r = 0; r < 27; r++) begin
            drive_vec(vecs[r]);
            @(negedge clk);
            if (vecs[r].chk) begin
                check($sformatf("vec%0d_valid", r), 32'(src_read[vecs[r].lane][0].valid), 32'(vecs[r].ev));
                check($sformatf("vec%0d_tag", r), 32'(src_read[vecs[r].lane][0].tag), 32'(vecs[r].et));
                if (vecs[r].chkd)
                    check($sformatf("vec%0d_data", r), src_read[vecs[r].lane][0].data, vecs[r].ed);
            end
            @(posedge clk);
            #1;
        end

        // Table ends with all entries in their reset state.
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset_n = ($urandom_range(63) != 0);
            flush   = ($urandom_range(15) == 0);
            for (int m = 0; m < IW; m++) begin
                issue_valid[m] = 1'($urandom_range(1));
                issue_dst[m]   = 6'($urandom_range(7));
                issue_tag[m]   = 4'($urandom);
            end
            for (int c = 0; c < CW; c++) begin
                commit_valid[c]    = 1'($urandom_range(1));
                commit_arch_num[c] = 6'($urandom_range(7));
                commit_tag[c]      = ($urandom_range(3) != 0) ? m_t[$urandom_range(7)] : 4'($urandom);
                commit_data[c]     = $urandom;
            end
            if (commit_tag[1] == commit_tag[0])
                commit_tag[1] = commit_tag[0] + 4'd1;
            for (int j = 0; j < IW; j++)
                for (int k = 0; k < SP; k++)
                    src_num[j][k] = 6'($urandom_range(7));
            @(negedge clk);
            for (int j = 0; j < IW; j++) begin
                for (int k = 0; k < SP; k++) begin
                    logic        ev, fwd;
                    logic [3:0]  et;
                    logic [31:0] ed;
                    model_read(j, src_num[j][k], ev, et, ed, fwd);
                    check($sformatf("rand%0d_l%0d_s%0d_valid", cyc, j, k), 32'(src_read[j][k].valid), 32'(ev));
                    check($sformatf("rand%0d_l%0d_s%0d_tag", cyc, j, k), 32'(src_read[j][k].tag), 32'(et));
                    if (!fwd)
                        check($sformatf("rand%0d_l%0d_s%0d_data", cyc, j, k), src_read[j][k].data, ed);
                end
            end
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file_multi.md
Name: register_file_multi

Overview:
- Parametrised successor to the single-issue renaming register file.
- Holds, per architectural register: committed data, a valid bit, and the ROB tag of the latest in-flight producer.
- Supports ISSUE_WIDTH issue lanes, COMMIT_WIDTH commit lanes and a flush.
- Source reads are forwarded across earlier lanes of the same issue group and across same-cycle commits, so dispatch sees correct operands with zero latency.

Parameters:
REG_WIDTH, 6, architectural register index width (2**REG_WIDTH entries)
ROB_WIDTH, 4, ROB tag width
DATA_WIDTH, 32, register data width
ISSUE_WIDTH, 2, instructions renamed per cycle
COMMIT_WIDTH, 2, instructions retired per cycle
SRC_PER_INST, 2, source operands read per issue lane

Ports:
clk  in  1  clock; all state updates on posedge
reset_n  in  1  synchronous, active-low reset
flush  in  1  mispredict recovery; clears all pending producers
issue_valid  in  ISSUE_WIDTH  per-lane issue enable
issue_dst  in  ISSUE_WIDTH x REG_WIDTH  destination register per lane
issue_tag  in  ISSUE_WIDTH x ROB_WIDTH  ROB tag allocated per lane
src_num  in  ISSUE_WIDTH x SRC_PER_INST x REG_WIDTH  source indices
src_read  out  ISSUE_WIDTH x SRC_PER_INST x cdb_t  {valid, tag, data} per source
commit_valid  in  COMMIT_WIDTH  per-lane commit enable
commit_arch_num  in  COMMIT_WIDTH x REG_WIDTH  retiring destination
commit_tag  in  COMMIT_WIDTH x ROB_WIDTH  retiring ROB tag
commit_data  in  COMMIT_WIDTH x DATA_WIDTH  retiring result

Behaviour:
- Reset (reset_n=0 at posedge): every entry gets valid=1, tag=0, data=0.
  - src_read is combinational, so it reflects reset state from the next cycle.
- Lane ordering: lane 0 is oldest, for both issue and commit.
- Source read, combinational, zero latency. Priority for src_read[j][k]:
  1. Nearest earlier issue lane m<j with issue_valid[m] and issue_dst[m]==src: valid=0, tag=issue_tag[m], data=don't-care.
  2. Else, stored entry has valid=0 and some commit lane c has commit_valid[c] and commit_tag[c]==stored tag: valid=1, data=commit_data[c].
  3. Else the stored entry.
  - A lane never forwards from itself or from later lanes.
- flush: this cycle's issue_valid is ignored.
- Per-entry valid update at posedge, priority order:
  1. reset_n=0 -> 1
  2. flush -> 1
  3. any issue lane with issue_dst==i -> 0
  4. any commit lane with tag==stored tag and stored valid=0 -> 1
  5. otherwise hold.
- Tag update: on issue to entry i, tag <= issue_tag of the highest matching lane.
  - Same-cycle issue and commit to one entry: issue wins; the entry stays pending on the new tag.
- Data update:
  - On any commit with commit_arch_num==i, data <= commit_data of the highest matching lane.
  - This happens regardless of valid, tag match or flush.
  - Committed values are architectural and must survive a flush.
- Data is never written on reset_n=0 except to clear to 0.
- Commit with a stale tag (entry re-issued since): data updates, valid remains 0.
- Commits in the flush cycle still write data.
- Tags wrap modulo 2**ROB_WIDTH. Uniqueness of in-flight tags is the ROB's responsibility; this block does no checking.
- Commit-bypass path (priority 2) is purely combinational from commit inputs. Commit inputs must be driven from registered ROB state to avoid loops.

Decomposition:
- common.vh / shared package holds cdb_t ({valid, tag, data}), REG_WIDTH, ROB_WIDTH and DATA_WIDTH.
- Sub-module register_file_entry: one per architectural register. It contains the valid/tag/data flops and the per-entry issue/commit match-and-select logic, instantiated in a generate loop.
- Read forwarding stays in the top level.

Test Plan:
- Reset then read: reset_n=0 for 1 cycle; read r5 -> valid=1, tag=0, data=0.
- Issue r3 tag 7 on lane 0; next cycle commit r3 tag 7 data 0xDEADBEEF -> during commit, src read of r3 bypasses valid=1, data=0xDEADBEEF; after the edge, stored valid=1, data=0xDEADBEEF.
- Intra-group forwarding: lane 0 issues r4 tag 2; lane 1 issues r4 tag 3 with source r4 -> lane-1 source reads valid=0, tag=2; stored tag is 3 next cycle.
- Stale commit: issue r6 tag 1, then issue r6 tag 5, then commit r6 tag 1 data 0x11 -> data=0x11, valid=0, tag=5; a later commit with tag 5 sets valid=1.
- Flush: three registers pending; assert flush together with issue r2 tag 4 and commit r9 data 0x55 -> all valid=1, r2 not renamed, r9 data=0x55.
- Dual commit to one register: lanes 0 and 1 commit r8 with data 0xA and 0xB, tag 6 matching -> data=0xB, valid=1; then reset_n=0 mid-flight -> all entries valid=1, data=0.
